seven_seg_scan_ctrl: RTL

Time-multiplexed scan controller for a 4-digit common-anode seven-segment display. It holds a 16-bit display value and per-digit blank bits, and presents one digit at a time to the shared hex-to-segment decoder. It drives the matching digit enable with a dead-time gap between digits to prevent ghosting. New values are loaded through a ready/load handshake and committed only at frame boundaries, so a frame never shows a mix of old and new digits.

---
 rtl/seven_seg_scan_ctrl_if.sv | 21 ++
 rtl/seven_seg_scan_ctrl.sv | 98 +++++++++
 2 files changed

// File: rtl/seven_seg_scan_ctrl_if.sv
// Load handshake and display-drive bundle for the seven-segment scan controller.
// master = the block that loads values; slave = the scan controller itself.
interface seven_seg_scan_ctrl_if;
    logic        load;
    logic [15:0] data_in;
    logic [3:0]  blank_in;
    logic        ready;
    logic [3:0]  nibble;
    logic [3:0]  digit_n;
    logic        frame_start;

    modport master (
        output load, data_in, blank_in,
        input  ready, nibble, digit_n, frame_start
    );

    modport slave (
        input  load, data_in, blank_in,
        output ready, nibble, digit_n, frame_start
    );
endinterface

// File: rtl/seven_seg_scan_ctrl.sv
// Four-digit common-anode scan controller: double-buffered display value committed at frame
// boundaries, with an all-dark dead time at the start of every digit slot.
module seven_seg_scan_ctrl #(
    parameter int unsigned REFRESH_DIV = 100000,
    parameter int unsigned DEAD_CYCLES = 500
) (
    input logic                  clk,
    input logic                  rst_n,
    seven_seg_scan_ctrl_if.slave bus
);
    localparam int unsigned   CW      = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] CntLast = CW'(REFRESH_DIV - 1);
    localparam logic          StDead  = 1'b0;
    localparam logic          StOn    = 1'b1;

    logic [CW-1:0] r_cnt;
    logic [1:0]    r_dig;
    logic [15:0]   r_active;
    logic [3:0]    r_active_blank;
    logic [15:0]   r_pending;
    logic [3:0]    r_pending_blank;
    logic          r_pend_v;
    logic          r_commit;
    logic [3:0]    r_nibble;
    logic [3:0]    r_digit_n;
    logic          r_frame_start;

    logic          w_accept;
    logic          w_slot_end;
    logic          w_frame_end;
    logic          w_do_commit;
    logic [CW-1:0] w_cnt_d;
    logic [1:0]    w_dig_d;
    logic [15:0]   w_active_d;
    logic [3:0]    w_active_blank_d;
    logic          w_state_d;
    logic [3:0]    w_digit_n_d;

    assign w_accept    = bus.load & ~r_pend_v;
    assign w_slot_end  = (r_cnt == CntLast);
    assign w_frame_end = w_slot_end & (r_dig == 2'd3);
    assign w_do_commit = w_frame_end & r_pend_v;

    // Outputs are registered from next-state values so they line up with the current slot.
    always_comb begin
        w_cnt_d          = w_slot_end ? '0 : r_cnt + CW'(1);
        w_dig_d          = w_slot_end ? r_dig + 2'd1 : r_dig;
        w_active_d       = w_do_commit ? r_pending : r_active;
        w_active_blank_d = w_do_commit ? r_pending_blank : r_active_blank;
        w_state_d        = (32'(w_cnt_d) < DEAD_CYCLES) ? StDead : StOn;
        w_digit_n_d      = 4'b1111;
        if (w_state_d == StOn && !w_active_blank_d[w_dig_d]) begin
            w_digit_n_d = ~(4'b0001 << w_dig_d);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cnt           <= '0;
            r_dig           <= 2'd0;
            r_active        <= 16'h0000;
            r_active_blank  <= 4'b0000;
            r_pending       <= 16'h0000;
            r_pending_blank <= 4'b0000;
            r_pend_v        <= 1'b0;
            r_commit        <= 1'b0;
            r_nibble        <= 4'h0;
            r_digit_n       <= 4'b1111;
            r_frame_start   <= 1'b0;
        end else begin
            r_cnt          <= w_cnt_d;
            r_dig          <= w_dig_d;
            r_active       <= w_active_d;
            r_active_blank <= w_active_blank_d;
            r_commit       <= w_do_commit;
            r_digit_n      <= w_digit_n_d;
            r_frame_start  <= w_frame_end;
            if (w_slot_end) begin
                r_nibble <= w_active_d[{w_dig_d, 2'b00} +: 4];
            end
            if (w_accept) begin
                r_pending       <= bus.data_in;
                r_pending_blank <= bus.blank_in;
            end
            // pend_v holds through the commit cycle so a load there is refused.
            if (r_commit) begin
                r_pend_v <= 1'b0;
            end else if (w_accept) begin
                r_pend_v <= 1'b1;
            end
        end
    end

    assign bus.ready       = ~r_pend_v;
    assign bus.nibble      = r_nibble;
    assign bus.digit_n     = r_digit_n;
    assign bus.frame_start = r_frame_start;
endmodule
